// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: loadable synchronous instruction memory with registered read and streaming loader
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   read_enable, read_address       fetch request, sampled when stall is low
//   stall                           holds instruction/instr_valid/addr_error/parity_error
//   instruction, instr_valid        registered fetch result, valid one cycle after an accepted read
//   addr_error                      accepted address was >= DEPTH (instruction = NOP_WORD)
//   load_start, load_valid, load_data   loader control and auto-increment write stream
//   load_ready, load_done, load_count   loader status, words written since last load_start
//   parity_inject, parity_error     parity test hook and flag, active only with INSTR_MEM_PARITY_EN
// Optional feature macro: INSTR_MEM_PARITY_EN (per-word even parity bit stored on load)
module instr_mem_loadable #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_address,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  output logic                  addr_error,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_count,
  input  logic                  parity_inject,
  output logic                  parity_error
);
  typedef enum logic [1:0] {IDLE, LOADING, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic wr, in_range, byp;
  // the load pointer always equals the count of words written since load_start
  assign ptr = cnt[ADDR_WIDTH-1:0];
  assign load_count = cnt;
  // load_start wins over a same-cycle beat so a restart never writes
  assign wr = (state == LOADING) && load_valid && !load_start;
  assign in_range = {1'b0, read_address} < (ADDR_WIDTH+1)'(DEPTH);
  // write-first: a read hitting the word being loaded this edge sees the new data
  assign byp = wr && (read_address == ptr);
  assign rd_word = byp ? load_data : mem[read_address];
  always_comb begin
    state_nx = load_start ? LOADING : (wr && cnt == (ADDR_WIDTH+1)'(DEPTH-1)) ? DONE : state;
    load_ready = state == LOADING;
    load_done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (load_start) cnt <= '0;
      else if (wr) cnt <= cnt + 1'b1;
    end
  always_ff @(posedge clk)
    if (wr) mem[ptr] <= load_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
      addr_error <= 1'b0;
    end else if (!stall) begin
      instr_valid <= read_enable;
      addr_error <= read_enable && !in_range;
      if (read_enable) instruction <= in_range ? rd_word : NOP_WORD;
    end
`ifdef INSTR_MEM_PARITY_EN
  logic par [DEPTH];
  logic rd_par;
  always_ff @(posedge clk)
    if (wr) par[ptr] <= ^load_data ^ parity_inject;
  assign rd_par = byp ? (^load_data ^ parity_inject) : par[read_address];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) parity_error <= 1'b0;
    else if (!stall) parity_error <= read_enable && in_range && (rd_par != ^rd_word);
`else
  logic unused_parity;
  assign unused_parity = parity_inject;
  assign parity_error = 1'b0;
`endif
endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: scoreboard bench for instr_mem_loadable (64-word and 48-word instances)
module tb_instr_mem_loadable;
  localparam logic [31:0] BASE = 32'h01093822;
`ifdef INSTR_MEM_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  logic clk = 0, rst_n = 0, read_enable = 0, stall = 0;
  logic load_start = 0, load_valid = 0, parity_inject = 0;
  logic [5:0] read_address = '0;
  logic [31:0] load_data = '0;
  logic [31:0] a_instr, b_instr;
  logic a_valid, a_aerr, a_ready, a_done, a_perr;
  logic b_valid, b_aerr, b_ready, b_done, b_perr;
  logic [6:0] a_count, b_count;
  typedef struct {logic [31:0] instr; logic valid; logic aerr; logic perr;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [31:0] mdl [64];
  int compared = 0, mismatched = 0;

  instr_mem_loadable #(.DATA_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .read_enable(read_enable), .read_address(read_address),
    .stall(stall), .instruction(a_instr), .instr_valid(a_valid), .addr_error(a_aerr),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(a_ready), .load_done(a_done), .load_count(a_count),
    .parity_inject(parity_inject), .parity_error(a_perr));

  instr_mem_loadable #(.DATA_WIDTH(32), .DEPTH(48), .ADDR_WIDTH(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .read_enable(read_enable), .read_address(read_address),
    .stall(stall), .instruction(b_instr), .instr_valid(b_valid), .addr_error(b_aerr),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(b_ready), .load_done(b_done), .load_count(b_count),
    .parity_inject(parity_inject), .parity_error(b_perr));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input logic [5:0] addr, input logic [31:0] instr, input logic aerr, input logic perr);
    read_enable = 1;
    read_address = addr;
    sb.push_back('{instr, 1'b1, aerr, perr});
  endtask

  task automatic test_reset;
    #12;
    compared++;
    if ({a_instr, a_valid, a_aerr, a_perr, a_ready, a_done, a_count} !== 44'h0) begin
      mismatched++;
      $display("FAIL reset_a: got %h v%b e%b p%b r%b d%b c%0d want 0", a_instr, a_valid, a_aerr, a_perr, a_ready, a_done, a_count);
    end
    compared++;
    if ({b_instr, b_valid, b_aerr, b_ready, b_done, b_count} !== 43'h0) begin
      mismatched++;
      $display("FAIL reset_b: got %h v%b e%b r%b d%b c%0d want 0", b_instr, b_valid, b_aerr, b_ready, b_done, b_count);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_load;
    load_start = 1;
    tick();
    load_start = 0;
    compared++;
    if ({a_ready, a_done, a_count, b_ready} !== {1'b1, 1'b0, 7'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL load_enter: got r%b d%b c%0d br%b want r1 d0 c0 br1", a_ready, a_done, a_count, b_ready);
    end
    for (int i = 0; i < 64; i++) begin
      load_valid = 1;
      load_data = BASE + 32'(i);
      mdl[i] = load_data;
      tick();
      compared++;
      if (a_count !== 7'(i + 1)) begin
        mismatched++;
        $display("FAIL load_count: beat %0d got %0d want %0d", i, a_count, i + 1);
      end
    end
    compared++;
    if ({a_done, a_ready, b_done, b_ready, b_count} !== {4'b1010, 7'd48}) begin
      mismatched++;
      $display("FAIL load_done: got d%b r%b bd%b br%b bc%0d want d1 r0 bd1 br0 bc48", a_done, a_ready, b_done, b_ready, b_count);
    end
    load_data = 32'hFFFF_FFFF;
    tick();
    load_valid = 0;
    compared++;
    if ({a_done, a_count} !== {1'b1, 7'd64}) begin
      mismatched++;
      $display("FAIL done_ignore: got d%b c%0d want d1 c64", a_done, a_count);
    end
  endtask

  task automatic test_back_to_back;
    int addrs [3] = '{0, 1, 63};
    for (int k = 0; k < 3; k++) begin
      push_read(6'(addrs[k]), mdl[addrs[k]], 1'b0, 1'b0);
      tick();
      e = sb.pop_front();
      compared++;
      if ({a_instr, a_valid, a_aerr, a_perr} !== {e.instr, e.valid, e.aerr, e.perr}) begin
        mismatched++;
        $display("FAIL b2b_read: addr %0d got %h v%b e%b p%b want %h v%b e%b p%b", addrs[k], a_instr, a_valid, a_aerr, a_perr, e.instr, e.valid, e.aerr, e.perr);
      end
    end
    read_enable = 0;
    tick();
    compared++;
    if ({a_valid, a_instr} !== {1'b0, mdl[63]}) begin
      mismatched++;
      $display("FAIL idle_hold: got v%b %h want v0 %h", a_valid, a_instr, mdl[63]);
    end
  endtask

  task automatic test_out_of_range;
    int addrs [3] = '{47, 48, 50};
    logic aerr;
    for (int k = 0; k < 3; k++) begin
      aerr = addrs[k] >= 48;
      read_enable = 1;
      read_address = 6'(addrs[k]);
      tick();
      compared++;
      if ({b_instr, b_valid, b_aerr} !== {aerr ? 32'h0 : mdl[addrs[k]], 1'b1, aerr}) begin
        mismatched++;
        $display("FAIL oor_b: addr %0d got %h v%b e%b want %h v1 e%b", addrs[k], b_instr, b_valid, b_aerr, aerr ? 32'h0 : mdl[addrs[k]], aerr);
      end
      compared++;
      if ({a_instr, a_valid, a_aerr} !== {mdl[addrs[k]], 1'b1, 1'b0}) begin
        mismatched++;
        $display("FAIL oor_a: addr %0d got %h v%b e%b want %h v1 e0", addrs[k], a_instr, a_valid, a_aerr, mdl[addrs[k]]);
      end
    end
    read_enable = 0;
    tick();
    compared++;
    if ({b_instr, b_valid, b_aerr} !== 34'h0) begin
      mismatched++;
      $display("FAIL oor_clear: got %h v%b e%b want 0 v0 e0", b_instr, b_valid, b_aerr);
    end
  endtask

  task automatic test_stall;
    push_read(6'd10, mdl[10], 1'b0, 1'b0);
    tick();
    e = sb.pop_front();
    compared++;
    if ({a_instr, a_valid, a_aerr} !== {e.instr, e.valid, e.aerr}) begin
      mismatched++;
      $display("FAIL stall_pre: got %h v%b e%b want %h v%b e%b", a_instr, a_valid, a_aerr, e.instr, e.valid, e.aerr);
    end
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      read_address = 6'(20 + k);
      read_enable = k != 1;
      tick();
      compared++;
      if ({a_instr, a_valid} !== {mdl[10], 1'b1}) begin
        mismatched++;
        $display("FAIL stall_hold: cycle %0d got %h v%b want %h v1", k, a_instr, a_valid, mdl[10]);
      end
    end
    stall = 0;
    push_read(6'd30, mdl[30], 1'b0, 1'b0);
    tick();
    e = sb.pop_front();
    compared++;
    if ({a_instr, a_valid, a_aerr} !== {e.instr, e.valid, e.aerr}) begin
      mismatched++;
      $display("FAIL stall_release: got %h v%b e%b want %h v%b e%b", a_instr, a_valid, a_aerr, e.instr, e.valid, e.aerr);
    end
    read_enable = 0;
    tick();
  endtask

  task automatic test_read_during_write;
    load_start = 1;
    tick();
    load_start = 0;
    for (int i = 0; i < 10; i++) begin
      load_valid = 1;
      load_data = (i == 5) ? 32'hDEAD_BEEF : 32'hC0DE_0000 + 32'(i);
      mdl[i] = load_data;
      if (i == 5) push_read(6'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
      tick();
      read_enable = 0;
      if (i == 5) begin
        e = sb.pop_front();
        compared++;
        if ({a_instr, a_valid, b_instr} !== {e.instr, e.valid, e.instr}) begin
          mismatched++;
          $display("FAIL rdw_bypass: got a=%h v%b b=%h want %h v1", a_instr, a_valid, b_instr, e.instr);
        end
      end
    end
    load_valid = 0;
    compared++;
    if (a_count !== 7'd10) begin
      mismatched++;
      $display("FAIL rdw_count: got %0d want 10", a_count);
    end
  endtask

  task automatic test_reset_mid_load;
    #2;
    rst_n = 0;
    #1;
    compared++;
    if ({a_instr, a_valid, a_aerr, a_ready, a_done, a_count} !== 43'h0) begin
      mismatched++;
      $display("FAIL async_reset: got %h v%b e%b r%b d%b c%0d want 0", a_instr, a_valid, a_aerr, a_ready, a_done, a_count);
    end
    @(negedge clk);
    rst_n = 1;
    load_start = 1;
    tick();
    load_start = 0;
    load_valid = 1;
    load_data = 32'h0000_0055;
    mdl[0] = load_data;
    tick();
    compared++;
    if ({a_ready, a_count} !== {1'b1, 7'd1}) begin
      mismatched++;
      $display("FAIL restart_ptr: got r%b c%0d want r1 c1", a_ready, a_count);
    end
    load_start = 1;
    load_data = 32'h0000_0BAD;
    tick();
    load_start = 0;
    load_valid = 0;
    compared++;
    if (a_count !== 7'd0) begin
      mismatched++;
      $display("FAIL restart_ignore: got c%0d want 0", a_count);
    end
    for (int i = 0; i < 10; i++) begin
      push_read(6'(i), mdl[i], 1'b0, 1'b0);
      tick();
      e = sb.pop_front();
      compared++;
      if ({a_instr, a_valid, a_aerr} !== {e.instr, e.valid, e.aerr}) begin
        mismatched++;
        $display("FAIL retained: addr %0d got %h v%b e%b want %h v%b e%b", i, a_instr, a_valid, a_aerr, e.instr, e.valid, e.aerr);
      end
    end
    read_enable = 0;
    tick();
  endtask

  task automatic test_parity;
    int addrs [3] = '{3, 4, 2};
    load_start = 1;
    tick();
    load_start = 0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1;
      load_data = 32'h1234_5670 + 32'(i);
      parity_inject = i == 3;
      mdl[i] = load_data;
      tick();
    end
    load_valid = 0;
    parity_inject = 0;
    for (int k = 0; k < 3; k++) begin
      push_read(6'(addrs[k]), mdl[addrs[k]], 1'b0, addrs[k] == 3 ? PAR_EN : 1'b0);
      tick();
      e = sb.pop_front();
      compared++;
      if ({a_instr, a_valid, a_perr} !== {e.instr, e.valid, e.perr}) begin
        mismatched++;
        $display("FAIL parity_read: addr %0d got %h v%b p%b want %h v%b p%b", addrs[k], a_instr, a_valid, a_perr, e.instr, e.valid, e.perr);
      end
    end
    read_enable = 0;
    tick();
    compared++;
    if ({a_valid, a_perr} !== 2'b00) begin
      mismatched++;
      $display("FAIL parity_clear: got v%b p%b want v0 p0", a_valid, a_perr);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_out_of_range();
    test_stall();
    test_read_during_write();
    test_reset_mid_load();
    test_parity();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
Parametrised synchronous instruction memory. Successor to the fixed 64x32 combinational instruction ROM in the fetch stage. Adds:
- configurable width and depth;
- a registered read with stall/valid handshake to the fetch stage;
- a streaming auto-increment load port so a bench or boot loader can program the contents at run time.

Parameters:
DATA_WIDTH, 32, instruction word width in bits.
DEPTH, 64, number of words; any value 2..4096, not required to be a power of two.
ADDR_WIDTH, 6, word-address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
NOP_WORD, 32'h00000000, value driven on Instruction at reset and on out-of-range reads.

Ports:
Clock  input  1  system clock, rising edge.
ResetN  input  1  asynchronous active-low reset.
ReadEnable  input  1  fetch request; ReadAddress sampled on the rising edge when high and Stall low.
ReadAddress  input  ADDR_WIDTH  word address of the instruction to fetch.
Stall  input  1  high holds Instruction/InstrValid/AddrError unchanged.
Instruction  output  DATA_WIDTH  registered instruction word.
InstrValid  output  1  high one cycle after an accepted read.
AddrError  output  1  registered; high alongside InstrValid when the accepted address >= DEPTH.
LoadStart  input  1  resets the load pointer to 0 and enters LOADING.
LoadValid  input  1  LoadData present this cycle.
LoadData  input  DATA_WIDTH  word to write at the load pointer.
LoadReady  output  1  high in LOADING.
LoadDone  output  1  high in DONE.
LoadCount  output  ADDR_WIDTH+1  number of words written since the last LoadStart.
ParityInject  input  1  test-only; used solely under INSTR_MEM_PARITY_EN.
ParityError  output  1  registered parity-mismatch flag.

Behaviour:
- Storage: DEPTH x DATA_WIDTH array. Array is not reset; contents are retained across ResetN.
- Reset (async, ResetN low):
  - Instruction = NOP_WORD; InstrValid, AddrError, ParityError = 0.
  - Load FSM = IDLE; load pointer = 0; LoadCount = 0; LoadReady = LoadDone = 0.
- Read path, latency 1:
  - Edge with ReadEnable=1, Stall=0: Instruction <= mem[ReadAddress]; InstrValid <= 1; AddrError <= 0.
  - ReadAddress >= DEPTH: Instruction <= NOP_WORD; AddrError <= 1; InstrValid <= 1.
  - Edge with ReadEnable=0, Stall=0: InstrValid <= 0, AddrError <= 0; Instruction holds its last value.
  - Stall=1: every read output holds, regardless of ReadEnable.
- Load FSM states IDLE, LOADING, DONE:
  - IDLE -> LOADING on LoadStart.
  - LOADING:
    - LoadValid=1 writes LoadData at the pointer; pointer and LoadCount increment.
    - The write of word DEPTH-1 moves the FSM to DONE on the same edge.
    - LoadStart in LOADING restarts: pointer = 0, LoadCount = 0, and any same-cycle LoadValid is ignored.
  - DONE: LoadValid is ignored (no write, no wrap); LoadStart -> LOADING with pointer 0.
  - LoadValid outside LOADING: no effect.
- Read-during-write: if an accepted read address equals the load pointer while a load write occurs that edge, Instruction returns the new LoadData (write-first bypass).
- Reads are legal in any FSM state; no arbitration stall is required.

Optional Feature:
INSTR_MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed on load, inverted when ParityInject=1 during that write.
  - On an accepted in-range read, ParityError <= (stored parity != recomputed parity); it follows the InstrValid/Stall rules.
  - The word is still delivered unmodified.
- Undefined: no parity storage; ParityError tied 0; ParityInject ignored.

Test Plan:
1. Reset, then LoadStart, then 64 LoadValid beats of data 0x01093822+i -> LoadCount counts 1..64; LoadDone=1 after the 64th beat; LoadReady=0.
2. After test 1, read addresses 0,1,63 back-to-back -> one cycle later Instruction = 0x01093822, 0x01093823, 0x01093861; InstrValid=1 each cycle; AddrError=0.
3. DEPTH=48: read address 50 -> Instruction=0x00000000, AddrError=1, InstrValid=1; then ReadEnable=0 -> InstrValid=0, AddrError=0.
4. Stall=1 for 3 cycles with a changing ReadAddress -> Instruction/InstrValid frozen; first edge after Stall=0 returns the new address's data.
5. Reading address 5 on the same edge the loader writes 0xDEADBEEF at pointer 5 -> Instruction=0xDEADBEEF next cycle.
6. Pull ResetN low mid-load at pointer 10 -> outputs reset immediately; after a LoadStart the pointer restarts at 0. Words 0..9 remain readable with their previously loaded values.
7. With INSTR_MEM_PARITY_EN, load word 3 with ParityInject=1 -> read 3 gives ParityError=1 and the correct data; read 4 gives ParityError=0.
